// File: rtl/aes_round_pipe_reg.sv
// Round-loop pipeline register for the AES datapath.
// Stage 0 chooses between a block fed back from the round logic and a fresh
// block (state + key) from the input queue. It tags the chosen block with its
// Rcon. The block then moves through DEPTH register stages, and the last stage
// drives the out_* ports. A feedback block that arrives carrying LAST_RCON has
// finished its final round. It leaves the loop, is counted in blocks_done, and
// its slot goes to a waiting new block.
//
// Handshake semantics:
//   - A new block transfers on any rising edge where new_valid && new_ready.
//   - new_ready is combinational and depends only on out_ready, reset,
//     fb_valid and fb_rcon. It never depends on new_valid.
//   - Upstream holds new_state/new_key stable while new_valid is high and
//     new_ready is low.
//   - out_ready is a global enable. When it is low, every register holds, so
//     out_* stay constant until out_ready returns high. The last-stage block is
//     consumed on an edge where out_valid && out_ready.
module aes_round_pipe_reg #(
   parameter int         DATA_W    = 128,
   parameter int         DEPTH     = 2,
   parameter logic [7:0] INIT_RCON = 8'h01,
   parameter logic [7:0] LAST_RCON = 8'h36
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              new_valid,
   output logic              new_ready,
   input  logic [DATA_W-1:0] new_state,
   input  logic [DATA_W-1:0] new_key,
   input  logic              fb_valid,
   input  logic [DATA_W-1:0] fb_state,
   input  logic [DATA_W-1:0] fb_key,
   input  logic [7:0]        fb_rcon,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_state,
   output logic [DATA_W-1:0] out_key,
   output logic [7:0]        out_rcon,
   output logic [3:0]        occ,
   output logic [15:0]       blocks_done
);

   // Per-stage registers; index 0 is the loading stage, DEPTH-1 drives out_*.
   logic [DEPTH-1:0]  stg_valid;
   logic [DATA_W-1:0] stg_state [DEPTH];
   logic [DATA_W-1:0] stg_key   [DEPTH];
   logic [7:0]        stg_rcon  [DEPTH];

   logic              en;
   logic              fb_continue;
   logic              fb_retire;
   logic              sel_valid;
   logic [DATA_W-1:0] sel_state;
   logic [DATA_W-1:0] sel_key;
   logic [7:0]        sel_rcon;
   logic [3:0]        occ_q;
   logic [3:0]        occ_next;
   logic [15:0]       done_q;

   // Stage-0 source selection: a continuing feedback block always wins the slot.
   always_comb begin
      en          = out_ready && !reset;
      fb_continue = fb_valid && (fb_rcon != LAST_RCON);
      fb_retire   = fb_valid && (fb_rcon == LAST_RCON);
      sel_valid   = fb_continue || new_valid;
      sel_state   = new_state;
      sel_key     = new_key;
      sel_rcon    = INIT_RCON;
      if (fb_continue) begin
         sel_state = fb_state;
         sel_key   = fb_key;
         sel_rcon  = fb_rcon;
      end
   end

   assign new_ready = en && !fb_continue;

   // Occupancy bookkeeping: one block enters and/or one leaves per enabled edge.
   always_comb begin
      occ_next = occ_q + 4'(sel_valid) - 4'(stg_valid[DEPTH-1]);
   end

   // Stage registers: load stage 0, shift the rest. On a bubble, data is held.
   always_ff @(posedge clock) begin
      if (reset) begin
         stg_valid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            stg_state[k] <= '0;
            stg_key[k]   <= '0;
            stg_rcon[k]  <= '0;
         end
      end else if (en) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            stg_valid[k] <= stg_valid[k-1];
            stg_state[k] <= stg_state[k-1];
            stg_key[k]   <= stg_key[k-1];
            stg_rcon[k]  <= stg_rcon[k-1];
         end
         stg_valid[0] <= sel_valid;
         if (sel_valid) begin
            stg_state[0] <= sel_state;
            stg_key[0]   <= sel_key;
            stg_rcon[0]  <= sel_rcon;
         end
      end
   end

   // Registered count of valid stages; it holds while the pipeline is stalled.
   always_ff @(posedge clock) begin
      if (reset) begin
         occ_q <= '0;
      end else if (en) begin
         occ_q <= occ_next;
      end
   end

   // Retired-block counter; it wraps naturally at 16 bits.
   always_ff @(posedge clock) begin
      if (reset) begin
         done_q <= '0;
      end else if (en && fb_retire) begin
         done_q <= done_q + 16'd1;
      end
   end

   assign out_valid   = stg_valid[DEPTH-1];
   assign out_state   = stg_state[DEPTH-1];
   assign out_key     = stg_key[DEPTH-1];
   assign out_rcon    = stg_rcon[DEPTH-1];
   assign occ         = occ_q;
   assign blocks_done = done_q;

endmodule

// File: tb/tb_aes_round_pipe_reg.sv
// Bench for aes_round_pipe_reg. It drives instances with DEPTH 1, 2 and 4 from
// the same inputs. Each instance has a reference model: a FIFO of admitted
// blocks, each stamped with the enabled-edge count at which it was admitted.
module tb_aes_round_pipe_reg;

   localparam logic [7:0] LAST = 8'h36;
   localparam logic [7:0] INIT = 8'h01;

   typedef struct packed {
      logic [127:0] st;
      logic [127:0] ky;
      logic [7:0]   rc;
      logic [31:0]  idx;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         new_valid;
   logic [127:0] new_state;
   logic [127:0] new_key;
   logic         fb_valid;
   logic [127:0] fb_state;
   logic [127:0] fb_key;
   logic [7:0]   fb_rcon;
   logic         out_ready;
   logic         last_acc = 1'b0;

   int checks   = 0;
   int failures = 0;

   // clock / reset block
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int d, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL d%0d %s actual=%0h required=%0h", d, nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      logic         nr;
      logic         ov;
      logic [127:0] os;
      logic [127:0] ok;
      logic [7:0]   orc;
      logic [3:0]   oc;
      logic [15:0]  bd;

      aes_round_pipe_reg #(.DATA_W(128), .DEPTH(D), .INIT_RCON(INIT),
                           .LAST_RCON(LAST)) dut (
         .clock(clock), .reset(reset),
         .new_valid(new_valid), .new_ready(nr),
         .new_state(new_state), .new_key(new_key),
         .fb_valid(fb_valid), .fb_state(fb_state), .fb_key(fb_key),
         .fb_rcon(fb_rcon), .out_ready(out_ready),
         .out_valid(ov), .out_state(os), .out_key(ok), .out_rcon(orc),
         .occ(oc), .blocks_done(bd)
      );

      exp_t        exp_q[$];
      logic [15:0] done_m   = '0;
      logic [31:0] en_cnt   = '0;
      logic        armed    = 1'b0;
      logic        rst_flag = 1'b0;

      // scoreboard: record admissions and retirements at each edge
      always @(posedge clock) begin
         exp_t e;
         if (reset) begin
            exp_q.delete();
            done_m   = '0;
            armed    = 1'b1;
            rst_flag = 1'b1;
         end else begin
            rst_flag = 1'b0;
            if (out_ready) begin
               en_cnt = en_cnt + 1;
               if (fb_valid && fb_rcon != LAST) begin
                  e = '{st: fb_state, ky: fb_key, rc: fb_rcon, idx: en_cnt};
                  exp_q.push_back(e);
               end else if (new_valid) begin
                  e = '{st: new_state, ky: new_key, rc: INIT, idx: en_cnt};
                  exp_q.push_back(e);
               end
               if (fb_valid && fb_rcon == LAST) done_m = done_m + 16'd1;
            end
         end
      end

      // monitor: compare the DUT against the model away from the active edge
      always @(negedge clock) begin
         exp_t h;
         logic exp_ov;
         logic exp_nr;
         if (armed) begin
            exp_nr = out_ready && !reset && !(fb_valid && fb_rcon != LAST);
            exp_ov = (exp_q.size() != 0) && (exp_q[0].idx + 32'(D - 1) == en_cnt);
            chk("new_ready", D, 128'(nr), 128'(exp_nr));
            chk("occ", D, 128'(oc), 128'(exp_q.size()));
            chk("blocks_done", D, 128'(bd), 128'(done_m));
            chk("out_valid", D, 128'(ov), 128'(exp_ov));
            if (exp_ov) begin
               h = exp_q[0];
               chk("out_state", D, os, h.st);
               chk("out_key", D, ok, h.ky);
               chk("out_rcon", D, 128'(orc), 128'(h.rc));
               if (out_ready && !reset) exp_q.pop_front();
            end
            if (rst_flag) begin
               chk("rst_state", D, os, 128'd0);
               chk("rst_key", D, ok, 128'd0);
               chk("rst_rcon", D, 128'(orc), 128'd0);
            end
         end
      end
   end

   // driver: one clock edge; a new block refreshes after it is accepted
   task automatic step();
      logic a;
      @(posedge clock);
      a = new_valid && g_dut[1].nr;
      #1;
      last_acc = a;
      if (a) begin
         new_state = {$urandom, $urandom, $urandom, $urandom};
         new_key   = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic rand_fb();
      fb_state = {$urandom, $urandom, $urandom, $urandom};
      fb_key   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   logic [127:0] saved_os;
   logic [15:0]  saved_bd;

   initial begin
      reset     = 1'b1;
      new_valid = 1'b1;
      new_state = {$urandom, $urandom, $urandom, $urandom};
      new_key   = {$urandom, $urandom, $urandom, $urandom};
      fb_valid  = 1'b0;
      fb_rcon   = 8'h00;
      out_ready = 1'b1;
      rand_fb();

      // reset held for three cycles while a block is offered
      repeat (3) step();
      @(negedge clock);
      chk("reset_new_ready", 2, 128'(g_dut[1].nr), 128'd0);
      chk("reset_out_valid", 2, 128'(g_dut[1].ov), 128'd0);
      reset = 1'b0;
      step();
      @(negedge clock);
      chk("first_occ", 2, 128'(g_dut[1].oc), 128'd1);
      step();
      @(negedge clock);
      chk("second_occ", 2, 128'(g_dut[1].oc), 128'd2);
      chk("first_out_valid", 2, 128'(g_dut[1].ov), 128'd1);
      chk("first_out_rcon", 2, 128'(g_dut[1].orc), 128'h01);

      // simultaneous offer: feedback wins
      fb_valid = 1'b1;
      fb_rcon  = 8'h04;
      rand_fb();
      @(negedge clock);
      chk("sim_new_ready", 2, 128'(g_dut[1].nr), 128'd0);
      step();
      fb_valid = 1'b0;
      step();
      step();

      // retirement frees the slot for a new block
      fb_valid  = 1'b1;
      fb_rcon   = LAST;
      new_valid = 1'b1;
      @(negedge clock);
      chk("ret_new_ready", 2, 128'(g_dut[1].nr), 128'd1);
      saved_bd = g_dut[1].bd;
      step();
      fb_valid = 1'b0;
      @(negedge clock);
      chk("ret_blocks_done", 2, 128'(g_dut[1].bd), 128'(saved_bd + 16'd1));

      // stall for four cycles
      out_ready = 1'b0;
      @(negedge clock);
      saved_os = g_dut[1].os;
      saved_bd = g_dut[1].bd;
      repeat (4) begin
         step();
         @(negedge clock);
         chk("stall_out_state", 2, g_dut[1].os, saved_os);
         chk("stall_blocks_done", 2, 128'(g_dut[1].bd), 128'(saved_bd));
      end
      out_ready = 1'b1;

      // reset while blocks are in flight
      for (int i = 0; i < 10 && g_dut[1].oc != 4'd2; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("midrst_out_valid", 2, 128'(g_dut[1].ov), 128'd0);
      chk("midrst_occ", 2, 128'(g_dut[1].oc), 128'd0);
      chk("midrst_blocks_done", 2, 128'(g_dut[1].bd), 128'd0);

      // randomized traffic with stalls, retirements and occasional resets
      for (int i = 0; i < 3000; i++) begin
         out_ready = ($urandom_range(0, 9) < 8);
         fb_valid  = ($urandom_range(0, 9) < 4);
         fb_rcon   = ($urandom_range(0, 3) == 0) ? LAST : 8'($urandom);
         rand_fb();
         if (!(new_valid && !last_acc)) new_valid = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 199) == 0);
         step();
      end

      // counter wrap
      reset = 1'b1;
      step();
      reset     = 1'b0;
      new_valid = 1'b0;
      out_ready = 1'b1;
      fb_valid  = 1'b1;
      fb_rcon   = LAST;
      repeat (65535) step();
      @(negedge clock);
      chk("wrap_ffff", 2, 128'(g_dut[1].bd), 128'hFFFF);
      step();
      @(negedge clock);
      chk("wrap_zero", 2, 128'(g_dut[1].bd), 128'd0);

      // drain
      fb_valid = 1'b0;
      repeat (8) step();
      @(negedge clock);
      chk("drain_occ_d1", 1, 128'(g_dut[0].oc), 128'd0);
      chk("drain_occ_d2", 2, 128'(g_dut[1].oc), 128'd0);
      chk("drain_occ_d4", 4, 128'(g_dut[2].oc), 128'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
